sobel_edge_pipe: RTL and testbench

Parametrised, stream-handshaked successor of the single-threshold Sobel edge stage. Accepts one 3x3 pixel window per transfer from the line buffer, computes horizontal and vertical Sobel gradients, and combines them under a runtime-selectable magnitude mode. It emits a saturated magnitude pixel plus an edge flag against a runtime threshold, and passes frame/line sideband through a 3-stage stallable pipeline.

---
 rtl/sobel_pkg.sv | 10 +
 rtl/sobel_grad.sv | 18 +
 rtl/sobel_edge_pipe.sv | 81 ++++++++
 tb/tb_sobel_edge_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared magnitude-mode encodings and gradient width helper for Sobel-family filters
package sobel_pkg;
  localparam logic [1:0] MODE_L1  = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_GX  = 2'd2;
  localparam logic [1:0] MODE_GY  = 2'd3;
  function automatic int grad_w(input int pixel_w);
    return pixel_w + 3;
  endfunction
endpackage

// File: rtl/sobel_grad.sv
// sobel_grad: combinational Sobel Gx/Gy from a row-major 3x3 window
module sobel_grad
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int GRAD_W  = grad_w(PIXEL_W)
) (
  input  logic [9*PIXEL_W-1:0]     window,
  output logic signed [GRAD_W-1:0] gx,
  output logic signed [GRAD_W-1:0] gy
);
  logic signed [GRAD_W-1:0] p [9];
  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = $signed({{(GRAD_W-PIXEL_W){1'b0}}, window[i*PIXEL_W +: PIXEL_W]});
    gy = p[0] + (p[1] <<< 1) + p[2] - p[6] - (p[7] <<< 1) - p[8];
    gx = p[0] + (p[3] <<< 1) + p[6] - p[2] - (p[5] <<< 1) - p[8];
  end
endmodule

// File: rtl/sobel_edge_pipe.sv
// sobel_edge_pipe: 3-stage stallable Sobel magnitude/edge pipeline with per-window mode and threshold
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int GRAD_W  = grad_w(PIXEL_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*PIXEL_W-1:0] in_window,
  input  logic                 in_sof,
  input  logic                 in_eol,
  input  logic [GRAD_W-1:0]    threshold,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIXEL_W-1:0]   out_mag,
  output logic                 out_edge,
  output logic                 out_sof,
  output logic                 out_eol
);
  logic signed [GRAD_W-1:0] gx_s, gy_s, gx_q, gy_q, gx_d, gy_d;
  logic [GRAD_W-1:0] th1_q, th1_d, th2_q, th2_d, mag2_q, mag2_d, ax, ay, mag_s;
  logic [GRAD_W:0] l1;
  logic [PIXEL_W-1:0] mag3_q, mag3_d;
  logic [1:0] mode1_q, mode1_d;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic sof1_q, sof1_d, eol1_q, eol1_d, sof2_q, sof2_d, eol2_q, eol2_d;
  logic sof3_q, sof3_d, eol3_q, eol3_d, edge3_q, edge3_d;
  logic advance;
  sobel_grad #(.PIXEL_W(PIXEL_W), .GRAD_W(GRAD_W)) u_grad (
    .window (in_window),
    .gx     (gx_s),
    .gy     (gy_s)
  );
  always_comb begin
    advance = !v3_q || out_ready;
    ax = gx_q[GRAD_W-1] ? -gx_q : gx_q;
    ay = gy_q[GRAD_W-1] ? -gy_q : gy_q;
    l1 = {1'b0, ax} + {1'b0, ay};
    mag_s = mode1_q == MODE_L1  ? (l1[GRAD_W] ? '1 : l1[GRAD_W-1:0]) :
            mode1_q == MODE_MAX ? (ax > ay ? ax : ay) :
            mode1_q == MODE_GX  ? ax : ay;
    v1_d    = advance ? in_valid : v1_q;
    gx_d    = advance ? gx_s : gx_q;
    gy_d    = advance ? gy_s : gy_q;
    th1_d   = advance ? threshold : th1_q;
    mode1_d = advance ? mode : mode1_q;
    sof1_d  = advance ? in_sof : sof1_q;
    eol1_d  = advance ? in_eol : eol1_q;
    v2_d    = advance ? v1_q : v2_q;
    mag2_d  = advance ? mag_s : mag2_q;
    th2_d   = advance ? th1_q : th2_q;
    sof2_d  = advance ? sof1_q : sof2_q;
    eol2_d  = advance ? eol1_q : eol2_q;
    v3_d    = advance ? v2_q : v3_q;
    mag3_d  = advance ? (|mag2_q[GRAD_W-1:PIXEL_W] ? '1 : mag2_q[PIXEL_W-1:0]) : mag3_q;
    edge3_d = advance ? mag2_q > th2_q : edge3_q;
    sof3_d  = advance ? sof2_q : sof3_q;
    eol3_d  = advance ? eol2_q : eol3_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {v1_q, gx_q, gy_q, th1_q, mode1_q, sof1_q, eol1_q} <= '0;
      {v2_q, mag2_q, th2_q, sof2_q, eol2_q} <= '0;
      {v3_q, mag3_q, edge3_q, sof3_q, eol3_q} <= '0;
    end else begin
      {v1_q, gx_q, gy_q, th1_q, mode1_q, sof1_q, eol1_q} <= {v1_d, gx_d, gy_d, th1_d, mode1_d, sof1_d, eol1_d};
      {v2_q, mag2_q, th2_q, sof2_q, eol2_q} <= {v2_d, mag2_d, th2_d, sof2_d, eol2_d};
      {v3_q, mag3_q, edge3_q, sof3_q, eol3_q} <= {v3_d, mag3_d, edge3_d, sof3_d, eol3_d};
    end
  end
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign out_mag   = mag3_q;
  assign out_edge  = edge3_q;
  assign out_sof   = sof3_q;
  assign out_eol   = eol3_q;
endmodule

// File: tb/tb_sobel_edge_pipe.sv
// tb_sobel_edge_pipe: directed self-checking bench for sobel_edge_pipe
module tb_sobel_edge_pipe;
  import sobel_pkg::*;
  logic clk, rst_n, in_valid, in_ready, in_sof, in_eol, out_valid, out_ready, out_edge, out_sof, out_eol;
  logic [71:0] in_window;
  logic [10:0] threshold;
  logic [1:0] mode;
  logic [7:0] out_mag;
  int checks, errors;
  sobel_edge_pipe #(.PIXEL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .threshold (threshold),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_edge  (out_edge),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [71:0] mk(input logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9);
    return {p9, p8, p7, p6, p5, p4, p3, p2, p1};
  endfunction
  // Drives one window with out_ready high and returns the first result plus its latency in cycles.
  task automatic run_single(input logic [71:0] w, input logic [10:0] th, input logic [1:0] md,
                            input logic s, input logic e, output logic [7:0] mag, output logic edg,
                            output logic os, output logic oe, output int lat);
    out_ready = 1; in_window = w; threshold = th; mode = md; in_sof = s; in_eol = e; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0; in_eol = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    mag = out_mag; edg = out_edge; os = out_sof; oe = out_eol;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 1; in_window = '0; threshold = '0; mode = MODE_L1; in_sof = 0; in_eol = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_mag, out_edge, out_sof, out_eol} !== 12'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 000", {out_valid, out_mag, out_edge, out_sof, out_eol});
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_flat();
    logic [7:0] m; logic ed, os, oe; int lat;
    run_single(mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 11'd100, MODE_L1, 1, 0, m, ed, os, oe, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL flat_latency: got %0d want 3", lat); end
    checks++;
    if ({m, ed, os, oe} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL flat_result: got mag=%0d edge=%b sof=%b eol=%b want mag=0 edge=0 sof=1 eol=0", m, ed, os, oe);
    end
  endtask
  task automatic test_column();
    logic [7:0] m; logic ed, os, oe; int lat;
    run_single(mk(255, 0, 0, 255, 0, 0, 255, 0, 0), 11'd100, MODE_L1, 0, 1, m, ed, os, oe, lat);
    checks++;
    if ({m, ed, os, oe} !== {8'd255, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL left_l1: got mag=%0d edge=%b sof=%b eol=%b want 255 1 0 1", m, ed, os, oe);
    end
    run_single(mk(255, 0, 0, 255, 0, 0, 255, 0, 0), 11'd100, MODE_GY, 0, 0, m, ed, os, oe, lat);
    checks++;
    if ({m, ed} !== {8'd0, 1'b0}) begin errors++; $display("FAIL left_gy: got mag=%0d edge=%b want 0 0", m, ed); end
    run_single(mk(0, 0, 255, 0, 0, 255, 0, 0, 255), 11'd100, MODE_GX, 0, 0, m, ed, os, oe, lat);
    checks++;
    if ({m, ed} !== {8'd255, 1'b1}) begin errors++; $display("FAIL right_gx: got mag=%0d edge=%b want 255 1", m, ed); end
  endtask
  task automatic test_threshold();
    logic [7:0] m; logic ed, os, oe; int lat;
    run_single(mk(0, 0, 0, 50, 0, 0, 0, 0, 0), 11'd100, MODE_MAX, 0, 0, m, ed, os, oe, lat);
    checks++;
    if ({m, ed} !== {8'd100, 1'b0}) begin errors++; $display("FAIL thr_equal: got mag=%0d edge=%b want 100 0", m, ed); end
    run_single(mk(0, 0, 0, 50, 0, 0, 0, 0, 0), 11'd99, MODE_MAX, 0, 0, m, ed, os, oe, lat);
    checks++;
    if ({m, ed} !== {8'd100, 1'b1}) begin errors++; $display("FAIL thr_below: got mag=%0d edge=%b want 100 1", m, ed); end
  endtask
  task automatic test_back_to_back();
    out_ready = 1; threshold = 11'd80; in_window = mk(0, 0, 0, 30, 0, 0, 0, 25, 0);
    mode = MODE_L1; in_valid = 1;
    @(posedge clk); #1;
    mode = MODE_MAX;
    @(posedge clk); #1;
    in_valid = 0; threshold = 11'd0; mode = MODE_GY;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_mag, out_edge} !== {1'b1, 8'd110, 1'b1}) begin
      errors++; $display("FAIL b2b_first: got v=%b mag=%0d edge=%b want 1 110 1", out_valid, out_mag, out_edge);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_mag, out_edge} !== {1'b1, 8'd60, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got v=%b mag=%0d edge=%b want 1 60 0", out_valid, out_mag, out_edge);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%b want 0", out_valid); end
  endtask
  task automatic test_backpressure();
    int sent, rcvd, extra;
    logic acc, stall_prev;
    logic [11:0] snap, exp_v;
    sent = 0; rcvd = 0; stall_prev = 0; snap = '0;
    threshold = 11'd20; mode = MODE_MAX;
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      out_ready = $urandom_range(0, 2) != 0;
      in_valid = sent < 20;
      in_window = mk(0, 0, 0, 8'(3 * sent + 1), 0, 0, 0, 0, 0);
      in_sof = sent == 0; in_eol = sent % 5 == 4;
      #4;
      if (stall_prev) begin
        checks++;
        if ({out_valid, out_mag, out_edge, out_sof, out_eol} !== snap) begin
          errors++; $display("FAIL bp_stable: got %h want %h", {out_valid, out_mag, out_edge, out_sof, out_eol}, snap);
        end
      end
      if (out_valid && out_ready) begin
        exp_v = {1'b1, 8'(6 * rcvd + 2), (6 * rcvd + 2) > 20, rcvd == 0, rcvd % 5 == 4};
        checks++;
        if ({out_valid, out_mag, out_edge, out_sof, out_eol} !== exp_v) begin
          errors++; $display("FAIL bp_data[%0d]: got %h want %h", rcvd, {out_valid, out_mag, out_edge, out_sof, out_eol}, exp_v);
        end
        rcvd++;
      end
      acc = in_valid && in_ready;
      stall_prev = out_valid && !out_ready;
      snap = {out_valid, out_mag, out_edge, out_sof, out_eol};
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 0; in_sof = 0; in_eol = 0; out_ready = 1;
    checks++;
    if (rcvd !== 20) begin errors++; $display("FAIL bp_count: got %0d want 20", rcvd); end
    extra = 0;
    repeat (5) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL bp_duplicates: got %0d extra want 0", extra); end
  endtask
  task automatic test_reset_inflight();
    logic [7:0] m; logic ed, os, oe; int lat;
    out_ready = 0; threshold = 11'd10; mode = MODE_MAX; in_window = mk(0, 0, 0, 50, 0, 0, 0, 0, 0); in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_fill: got v=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    rst_n = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid: got %b want 0", out_valid); end
    rst_n = 1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    run_single(mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 11'd100, MODE_L1, 0, 0, m, ed, os, oe, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rst_next_latency: got %0d want 3", lat); end
    checks++;
    if ({m, ed} !== {8'd0, 1'b0}) begin errors++; $display("FAIL rst_next_data: got mag=%0d edge=%b want 0 0", m, ed); end
  endtask
  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_flat();
    test_column();
    test_threshold();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
